boundary_scan_register: RTL and testbench

- Parametrised boundary-scan data register built from WIDTH boundary cells. Each cell has a capture/shift stage and an update stage.
- Sits between the TAP controller and the device pins: TAP strobes drive it, TDI/TDO chain through it, and pin-side data passes through it or is overridden in test mode.
- Single-clock successor to the per-cell design. Capture and update are clock enables on TCK, not clocks.
- New over the per-cell design: configurable width, reset safe-state, and a shift bit counter with a full-length flag.

---
 rtl/boundary_scan_register.sv | 74 +++++++
 tb/tb_boundary_scan_register.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/boundary_scan_register.sv
// Boundary-scan data register: WIDTH capture/shift cells with an update stage,
// pin-side mux and a saturating shift bit counter. Single clock, TAP strobes are enables.
module boundary_scan_register #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] SAFE_VALUE = '0,
    parameter int               CNT_W      = 16
) (
    input  logic             TCK,
    input  logic             RESET,
    input  logic             TDI,
    input  logic             CAPTURE,
    input  logic             SHIFT,
    input  logic             UPDATE,
    input  logic             MODE_SHIFT_LOAD,
    input  logic             MODE_TEST_NORMAL,
    input  logic [WIDTH-1:0] SYSTEM_DATA_IN,
    output logic [WIDTH-1:0] SYSTEM_DATA_OUT,
    output logic             TDOS,
    output logic [CNT_W-1:0] BIT_COUNT,
    output logic             CHAIN_FULL
);

    // A counter too narrow to reach WIDTH would leave CHAIN_FULL stuck low.
    if (WIDTH < 1 || CNT_W < 1 || CNT_W > 31 || WIDTH >= (2 ** CNT_W)) begin : g_bad_params
        $error("boundary_scan_register: need 1 <= WIDTH < 2**CNT_W");
    end

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] update_q, update_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;

    if (WIDTH == 1) begin : g_one
        assign shifted = TDI;
    end else begin : g_many
        assign shifted = {TDI, shift_q[WIDTH-1:1]};
    end

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        update_d = update_q;
        if (CAPTURE) begin
            shift_d = MODE_SHIFT_LOAD ? SYSTEM_DATA_IN : {WIDTH{TDI}};
            cnt_d   = '0;
        end else if (SHIFT) begin
            shift_d = shifted;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (UPDATE) begin
            update_d = shift_q;
        end
    end

    always_ff @(posedge TCK) begin
        if (RESET) begin
            shift_q  <= '0;
            update_q <= SAFE_VALUE;
            cnt_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            update_q <= update_d;
            cnt_q    <= cnt_d;
        end
    end

    assign SYSTEM_DATA_OUT = MODE_TEST_NORMAL ? SYSTEM_DATA_IN : update_q;
    assign TDOS            = shift_q[0];
    assign BIT_COUNT       = cnt_q;
    assign CHAIN_FULL      = (cnt_q >= CNT_W'(WIDTH));

endmodule

// File: tb/tb_boundary_scan_register.sv
// Bench for boundary_scan_register: directed scenarios plus random strobes,
// checked against an arithmetic reference model. Second instance uses CNT_W=4.
module tb_boundary_scan_register;

    localparam int         W    = 8;
    localparam logic [7:0] SAFE = 8'hA5;

    logic       TCK = 1'b0;
    logic       rst, tdi, cap, sh, upd, msl, mtn;
    logic [7:0] sdi;

    logic [7:0]  sdo, sdo4;
    logic        tdos, tdos4, full, full4;
    logic [15:0] bc;
    logic [3:0]  bc4;

    boundary_scan_register #(.WIDTH(W), .SAFE_VALUE(SAFE), .CNT_W(16)) dut (
        .TCK(TCK), .RESET(rst), .TDI(tdi), .CAPTURE(cap), .SHIFT(sh), .UPDATE(upd),
        .MODE_SHIFT_LOAD(msl), .MODE_TEST_NORMAL(mtn), .SYSTEM_DATA_IN(sdi),
        .SYSTEM_DATA_OUT(sdo), .TDOS(tdos), .BIT_COUNT(bc), .CHAIN_FULL(full)
    );

    boundary_scan_register #(.WIDTH(W), .SAFE_VALUE(SAFE), .CNT_W(4)) dut_sat (
        .TCK(TCK), .RESET(rst), .TDI(tdi), .CAPTURE(cap), .SHIFT(sh), .UPDATE(upd),
        .MODE_SHIFT_LOAD(msl), .MODE_TEST_NORMAL(mtn), .SYSTEM_DATA_IN(sdi),
        .SYSTEM_DATA_OUT(sdo4), .TDOS(tdos4), .BIT_COUNT(bc4), .CHAIN_FULL(full4)
    );

    always #5 TCK = ~TCK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state, as plain integers.
    int m_sr, m_ur, m_cnt, m_cnt4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int nur;
        if (rst) begin
            m_sr = 0; m_ur = int'(SAFE); m_cnt = 0; m_cnt4 = 0;
        end else begin
            nur = upd ? m_sr : m_ur;
            if (cap) begin
                m_sr   = msl ? int'(sdi) : (tdi ? 255 : 0);
                m_cnt  = 0;
                m_cnt4 = 0;
            end else if (sh) begin
                m_sr   = m_sr / 2 + int'(tdi) * 128;
                m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            end
            m_ur = nur;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".tdos"}, 32'(tdos), 32'(m_sr % 2));
        chk({tag, ".cnt"},  32'(bc),   32'(m_cnt));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt >= W));
        chk({tag, ".sdo"},  32'(sdo),  mtn ? 32'(sdi) : 32'(m_ur));
        chk({tag, ".cnt4"}, 32'(bc4),  32'(m_cnt4));
        chk({tag, ".full4"}, 32'(full4), 32'(m_cnt4 >= W));
    endtask

    task automatic step(input logic r, input logic c, input logic s, input logic u,
                        input logic t, input string tag);
        @(negedge TCK);
        rst = r; cap = c; sh = s; upd = u; tdi = t;
        @(posedge TCK);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic scenario2(input string tag);
        logic [7:0] seq;
        seq = 8'b1100_0011;   // seq[k] = TDOS before the k-th shift edge
        mtn = 1'b0; msl = 1'b1; sdi = 8'hC3;
        step(0, 1, 0, 0, 0, {tag, ".cap"});
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s.seq%0d", tag, k), 32'(tdos), 32'(seq[k]));
            step(0, 0, 1, 0, 0, $sformatf("%s.sh%0d", tag, k));
            chk($sformatf("%s.bc%0d", tag, k), 32'(bc), 32'(k + 1));
            chk($sformatf("%s.full%0d", tag, k), 32'(full), 32'(k == 7));
        end
    endtask

    initial begin
        rst = 1'b1; tdi = 0; cap = 0; sh = 0; upd = 0; msl = 0; mtn = 0; sdi = 8'h00;
        m_sr = 0; m_ur = 0; m_cnt = 0; m_cnt4 = 0;

        // 1: reset state and combinational pin mux
        step(1, 0, 0, 0, 0, "rst");
        chk("rst.sdo_safe", 32'(sdo), 32'h A5);
        chk("rst.tdos", 32'(tdos), 32'h0);
        chk("rst.bc", 32'(bc), 32'h0);
        chk("rst.full", 32'(full), 32'h0);
        mtn = 1'b1; sdi = 8'h3C;
        #1;
        chk("mode.sdo_normal", 32'(sdo), 32'h3C);
        step(0, 0, 0, 0, 0, "idle");

        // 2: capture then shift out
        scenario2("s2");

        // 3: shift in 5A, update, then shift without update
        begin
            logic [7:0] pat;
            pat = 8'h5A;
            mtn = 1'b0; msl = 1'b0;
            step(0, 1, 0, 0, 0, "s3.cap");
            for (int k = 0; k < 8; k++) step(0, 0, 1, 0, pat[k], $sformatf("s3.sh%0d", k));
            step(0, 0, 0, 1, 0, "s3.upd");
            chk("s3.sdo", 32'(sdo), 32'h5A);
            step(0, 0, 1, 0, 1, "s3.extra");
            chk("s3.sdo_hold", 32'(sdo), 32'h5A);
        end

        // 4: simultaneous strobes
        msl = 1'b1; sdi = 8'hF0;
        step(0, 1, 0, 0, 0, "s4.load");
        sdi = 8'h0F;
        step(0, 1, 1, 0, 0, "s4.capsh");
        chk("s4.capsh_bc", 32'(bc), 32'h0);
        chk("s4.capsh_tdos", 32'(tdos), 32'h1);
        step(0, 0, 1, 1, 1, "s4.shupd");
        chk("s4.upd_pre", 32'(sdo), 32'h0F);
        step(0, 0, 0, 1, 0, "s4.upd2");
        chk("s4.shift_87", 32'(sdo), 32'h87);

        // 5: counter saturation on the CNT_W=4 instance
        step(0, 1, 0, 0, 0, "s5.cap");
        for (int k = 0; k < 20; k++) step(0, 0, 1, 0, k[0], $sformatf("s5.sh%0d", k));
        chk("s5.bc4_sat", 32'(bc4), 32'd15);
        chk("s5.full4", 32'(full4), 32'h1);
        chk("s5.bc_wide", 32'(bc), 32'd20);
        step(0, 1, 0, 0, 0, "s5.recap");
        chk("s5.bc4_clr", 32'(bc4), 32'h0);
        chk("s5.full4_clr", 32'(full4), 32'h0);

        // 6: reset in mid-shift overrides strobes, then rerun scenario 2
        mtn = 1'b0;
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 1, $sformatf("s6.sh%0d", k));
        step(1, 0, 1, 1, 1, "s6.rst");
        chk("s6.sdo_safe", 32'(sdo), 32'h A5);
        chk("s6.bc", 32'(bc), 32'h0);
        chk("s6.tdos", 32'(tdos), 32'h0);
        step(0, 0, 0, 1, 0, "s6.upd0");
        chk("s6.shift_zero", 32'(sdo), 32'h00);
        scenario2("s6r");

        // random strobes against the model
        for (int i = 0; i < 300; i++) begin
            msl = 1'($urandom);
            mtn = 1'($urandom);
            sdi = 8'($urandom);
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
                 $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
